// File: rtl/tape_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : tape_sd_arbiter_if
//  Brief    : Request/grant and SD block-port bundle shared by tape channels.
//  Revision : 1.0 - initial release
// ============================================================================
interface tape_sd_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [31:0] req_lba0;
    logic [31:0] req_lba1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        sd_sel;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    // master: the arbiter itself; slave: channels plus SD host
    modport master (
        input  req, req_wr, req_lba0, req_lba1, sd_ack,
        output gnt, done, err, sd_sel, sd_lba, sd_rd, sd_wr
    );

    modport slave (
        output req, req_wr, req_lba0, req_lba1, sd_ack,
        input  gnt, done, err, sd_sel, sd_lba, sd_rd, sd_wr
    );
endinterface
`default_nettype wire

// File: rtl/tape_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tape_sd_arbiter
//  Brief    : Round-robin owner of the single SD block port for tape reader
//             (ch0) and punch (ch1), with per-transfer timeout abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tape_sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    tape_sd_arbiter_if.master bus
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_issue = 3'd1;
    localparam logic [2:0] c_xfer  = 3'd2;
    localparam logic [2:0] c_done  = 3'd3;
    localparam logic [2:0] c_abort = 3'd4;

    logic [2:0]  state_q,  state_d;
    logic        last_q,   last_d;
    logic [1:0]  gnt_q,    gnt_d;
    logic [1:0]  done_q,   done_d;
    logic        err_q,    err_d;
    logic        sd_sel_q, sd_sel_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        sd_rd_q,  sd_rd_d;
    logic        sd_wr_q,  sd_wr_d;
    logic [23:0] timer_q,  timer_d;

    logic w_pick;
    logic w_timeout;

    // Single requester wins outright; a tie goes to the channel not served last.
    assign w_pick    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    assign w_timeout = (timer_q == (TIMEOUT - 24'd1));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        err_d    = 1'b0;
        sd_sel_d = sd_sel_q;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        timer_d  = timer_q;

        if ((state_q == c_issue || state_q == c_xfer) && (timer_q != 24'hFFFFFF)) begin
            timer_d = timer_q + 24'd1;
        end

        case (state_q)
            c_idle: begin
                if (bus.req != 2'b00) begin
                    state_d  = c_issue;
                    sd_sel_d = w_pick;
                    gnt_d    = w_pick ? 2'b10 : 2'b01;
                    sd_lba_d = w_pick ? bus.req_lba1 : bus.req_lba0;
                    sd_rd_d  = ~bus.req_wr[w_pick];
                    sd_wr_d  = bus.req_wr[w_pick];
                    timer_d  = 24'd0;
                end
            end
            c_issue: begin
                // An ack seen on the timeout edge still counts as accepted.
                if (bus.sd_ack) begin
                    state_d = c_xfer;
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                end else if (w_timeout) begin
                    state_d          = c_abort;
                    sd_rd_d          = 1'b0;
                    sd_wr_d          = 1'b0;
                    done_d[sd_sel_q] = 1'b1;
                    err_d            = 1'b1;
                    last_d           = sd_sel_q;
                end
            end
            c_xfer: begin
                if (!bus.sd_ack) begin
                    state_d          = c_done;
                    done_d[sd_sel_q] = 1'b1;
                    last_d           = sd_sel_q;
                end else if (w_timeout) begin
                    state_d          = c_abort;
                    done_d[sd_sel_q] = 1'b1;
                    err_d            = 1'b1;
                    last_d           = sd_sel_q;
                end
            end
            c_done, c_abort: begin
                state_d  = c_idle;
                gnt_d    = 2'b00;
                sd_sel_d = 1'b0;
            end
            default: begin
                state_d  = c_idle;
                gnt_d    = 2'b00;
                sd_sel_d = 1'b0;
                sd_rd_d  = 1'b0;
                sd_wr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_idle;
            last_q   <= 1'b1;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
            sd_sel_q <= 1'b0;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            timer_q  <= 24'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sd_sel_q <= sd_sel_d;
            sd_lba_q <= sd_lba_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.sd_sel = sd_sel_q;
    assign bus.sd_lba = sd_lba_q;
    assign bus.sd_rd  = sd_rd_q;
    assign bus.sd_wr  = sd_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tape_sd_arbiter
//  Brief    : Directed and randomized bench for tape_sd_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tape_sd_arbiter;

    localparam logic [23:0] C_TIMEOUT = 24'd16;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    tape_sd_arbiter_if bus ();

    tape_sd_arbiter #(
        .TIMEOUT (C_TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one outstanding transaction record with progress flags.
    logic        m_busy;
    logic        m_owner;
    logic        m_wr;
    logic [31:0] m_lba;
    logic        m_acc;
    logic        m_fin;
    logic        m_abt;
    logic        m_last;
    logic [23:0] m_age;
    logic        m_pick;

    assign m_pick = (bus.req == 2'b11) ? !m_last : bus.req[1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_owner <= 1'b0;
            m_wr    <= 1'b0;
            m_lba   <= 32'd0;
            m_acc   <= 1'b0;
            m_fin   <= 1'b0;
            m_abt   <= 1'b0;
            m_last  <= 1'b1;
            m_age   <= 24'd0;
        end else if (!m_busy) begin
            if (bus.req != 2'b00) begin
                m_busy  <= 1'b1;
                m_owner <= m_pick;
                m_wr    <= bus.req_wr[m_pick];
                m_lba   <= m_pick ? bus.req_lba1 : bus.req_lba0;
                m_acc   <= 1'b0;
                m_fin   <= 1'b0;
                m_abt   <= 1'b0;
                m_age   <= 24'd0;
            end
        end else if (m_fin) begin
            m_busy <= 1'b0;
            m_fin  <= 1'b0;
        end else begin
            m_age <= (m_age == 24'hFFFFFF) ? m_age : m_age + 24'd1;
            if (!m_acc && bus.sd_ack) begin
                m_acc <= 1'b1;
            end else if (m_acc && !bus.sd_ack) begin
                m_fin  <= 1'b1;
                m_abt  <= 1'b0;
                m_last <= m_owner;
            end else if (m_age == C_TIMEOUT - 24'd1) begin
                m_fin  <= 1'b1;
                m_abt  <= 1'b1;
                m_last <= m_owner;
            end
        end
    end

    logic [1:0]  e_gnt;
    logic [39:0] e_vec;
    logic [39:0] a_vec;
    assign e_gnt = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    assign e_vec = {e_gnt, (m_fin ? e_gnt : 2'b00), m_fin & m_abt, m_busy & m_owner,
                    m_lba, m_busy & !m_acc & !m_fin & !m_wr, m_busy & !m_acc & !m_fin & m_wr};
    assign a_vec = {bus.gnt, bus.done, bus.err, bus.sd_sel, bus.sd_lba, bus.sd_rd, bus.sd_wr};

    always @(negedge clk) begin
        n_tests++;
        if (a_vec !== e_vec) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: actual gnt/done/err/sel/lba/rd/wr=%h required=%h",
                     $time, a_vec, e_vec);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int ack_rate;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.req       = 2'b00;
        bus.req_wr    = 2'b00;
        bus.req_lba0  = 32'd0;
        bus.req_lba1  = 32'd0;
        bus.sd_ack    = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {32'd0, a_vec}, 64'd0);
        reset = 1'b0;
        tick();

        // ch0 read at LBA 5
        bus.req = 2'b01; bus.req_wr = 2'b00; bus.req_lba0 = 32'd5;
        tick();
        chk("ch0_gnt", {62'd0, bus.gnt}, 64'h1);
        chk("ch0_rd_wr", {62'd0, bus.sd_rd, bus.sd_wr}, 64'h2);
        chk("ch0_lba", {32'd0, bus.sd_lba}, 64'd5);
        bus.sd_ack = 1'b1;
        tick(); tick(); tick();
        bus.sd_ack = 1'b0;
        tick();
        chk("ch0_done", {61'd0, bus.done, bus.err}, 64'h2);
        chk("ch0_gnt_in_done", {62'd0, bus.gnt}, 64'h1);
        bus.req = 2'b00;
        tick();
        chk("ch0_release", {60'd0, bus.gnt, bus.done}, 64'h0);

        // ch1 write at the top LBA
        bus.req = 2'b10; bus.req_wr = 2'b10; bus.req_lba1 = 32'hFFFF_FFFF;
        tick();
        chk("ch1_issue", {28'd0, bus.gnt, bus.sd_sel, bus.sd_rd, bus.sd_wr, bus.sd_lba},
            {28'd0, 2'b10, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF});
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick();
        chk("ch1_done", {61'd0, bus.done, bus.err}, 64'h4);
        bus.req = 2'b00;
        tick();

        // Both requesters from reset: strict alternation starting with ch0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 2'b11; bus.req_wr = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt", {62'd0, bus.gnt}, (k % 2 == 1) ? 64'h2 : 64'h1);
            bus.sd_ack = 1'b1;
            tick();
            bus.sd_ack = 1'b0;
            tick();
            chk("rr_done", {62'd0, bus.done}, (k % 2 == 1) ? 64'h2 : 64'h1);
            if (k == 3) bus.req = 2'b00;
            tick();
            chk("rr_gap", {62'd0, bus.gnt}, 64'h0);
            if (k < 3) tick();
        end

        // Timeout with no ack: abort 16 cycles after sd_rd rises
        bus.req = 2'b01; bus.req_wr = 2'b00;
        tick();
        chk("to_rd_rise", {63'd0, bus.sd_rd}, 64'h1);
        for (int i = 1; i < 16; i++) tick();
        chk("to_before", {61'd0, bus.done, bus.sd_rd}, 64'h1);
        tick();
        chk("to_abort", {60'd0, bus.done, bus.err, bus.sd_rd}, {60'd0, 2'b01, 1'b1, 1'b0});
        bus.req = 2'b10; bus.req_wr = 2'b00;
        tick();
        chk("to_idle", {62'd0, bus.gnt}, 64'h0);
        tick();
        chk("to_next_gnt", {62'd0, bus.gnt}, 64'h2);
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick();
        chk("to_next_done", {61'd0, bus.done, bus.err}, 64'h4);
        bus.req = 2'b00;
        tick();

        // Reset asserted during XFER
        bus.req = 2'b01;
        tick();
        bus.sd_ack = 1'b1;
        tick();
        bus.req = 2'b10;
        #1 reset = 1'b1;
        #1 chk("rst_xfer_outputs", {32'd0, a_vec}, 64'd0);
        @(posedge clk);
        #2;
        bus.sd_ack = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_then_ch1", {62'd0, bus.gnt}, 64'h2);
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick();
        chk("rst_ch1_done", {62'd0, bus.done}, 64'h2);
        bus.req = 2'b00;
        tick();

        // Late LBA change and dropped req are ignored
        bus.req = 2'b01; bus.req_wr = 2'b00; bus.req_lba0 = 32'h1234_5678;
        tick();
        bus.sd_ack = 1'b1;
        tick();
        bus.req_lba0 = 32'hDEAD_BEEF;
        bus.req = 2'b00;
        tick();
        chk("late_lba", {32'd0, bus.sd_lba}, 64'h1234_5678);
        bus.sd_ack = 1'b0;
        tick();
        chk("late_done", {62'd0, bus.done}, 64'h1);
        tick();
        chk("late_single", {62'd0, bus.done}, 64'h0);

        // Randomized traffic against the model
        ack_rate = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(2, 0))
                    0:       ack_rate = 2;
                    1:       ack_rate = 6;
                    default: ack_rate = 40;
                endcase
            end
            if ($urandom_range(7, 0) == 0) bus.req[0] = ~bus.req[0];
            if ($urandom_range(7, 0) == 0) bus.req[1] = ~bus.req[1];
            bus.req_wr   = 2'($urandom());
            bus.req_lba0 = $urandom();
            bus.req_lba1 = $urandom();
            if ($urandom_range(ack_rate - 1, 0) == 0) bus.sd_ack = ~bus.sd_ack;
            tick();
        end

        bus.req    = 2'b00;
        bus.sd_ack = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
